// File: rtl/btn_pkg.sv
// btn_pkg: register offsets and sizing helper shared by the button controller.
package btn_pkg;

    localparam logic [31:0] LEVEL_OFS = 32'h0;
    localparam logic [31:0] EVENT_OFS = 32'h4;
    localparam logic [31:0] IRQEN_OFS = 32'h8;

    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and press detector for one button.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic          differs, accept;

    assign differs = sync_q[1] != stable_q;
    assign accept  = differs && cnt_q == CNT_MAX;

    // Any sample that matches the accepted level restarts the window.
    always_comb begin
        cnt_d    = (!differs || accept) ? '0 : cnt_q + 1'b1;
        stable_d = accept ? sync_q[1] : stable_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

    assign level_o = stable_q;
    assign press_o = stable_q & ~prev_q;

endmodule

// File: rtl/btn_ctrl.sv
// btn_ctrl: memory-mapped push-button controller with debounced levels,
// sticky press flags (write-1-to-clear) and a maskable registered interrupt.
module btn_ctrl
    import btn_pkg::*;
#(
    parameter int          N_BTN           = 5,
    parameter int          DEBOUNCE_CYCLES = 20,
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_F078
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    input  logic [N_BTN-1:0] button,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam logic [31:0] A_LEVEL = BASE_ADDR + LEVEL_OFS;
    localparam logic [31:0] A_EVENT = BASE_ADDR + EVENT_OFS;
    localparam logic [31:0] A_IRQEN = BASE_ADDR + IRQEN_OFS;

    logic [N_BTN-1:0] level, press;
    logic [N_BTN-1:0] event_q, event_d;
    logic [N_BTN-1:0] irqen_q, irqen_d;
    logic [N_BTN-1:0] clr;
    logic             irq_q, irq_d;
    logic             wr_event, wr_irqen;
    logic             unused_wdata;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (button[i]),
            .level_o(level[i]),
            .press_o(press[i])
        );
    end

    assign wr_event     = we && addr == A_EVENT;
    assign wr_irqen     = we && addr == A_IRQEN;
    assign unused_wdata = &{1'b0, wdata};

    // A press arriving in the same cycle as its clear keeps the flag set.
    always_comb begin
        clr     = wr_event ? wdata[N_BTN-1:0] : '0;
        event_d = (event_q & ~clr) | press;
        irqen_d = wr_irqen ? wdata[N_BTN-1:0] : irqen_q;
        irq_d   = |(event_q & irqen_q);
        rdata   = addr == A_LEVEL ? 32'(level)   :
                  addr == A_EVENT ? 32'(event_q) :
                  addr == A_IRQEN ? 32'(irqen_q) : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            event_q <= '0;
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            event_q <= event_d;
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// tb_btn_ctrl: directed scoreboard bench for btn_ctrl with N_BTN=5, DEBOUNCE_CYCLES=4.
module tb_btn_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_F078;
    localparam logic [31:0] LV   = BASE;
    localparam logic [31:0] EV   = BASE + 32'h4;
    localparam logic [31:0] IE   = BASE + 32'h8;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [4:0]  button;
    logic [31:0] rdata;
    logic        irq;

    exp_t exp_q[$];
    event rd_ev;
    int   checks = 0;
    int   errors = 0;

    btn_ctrl #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(4),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .button(button),
        .rdata (rdata),
        .irq   (irq)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic i, input string nm);
        exp_t e;
        addr = a;
        #1;
        e.name = nm;
        e.data = d;
        e.irq  = i;
        exp_q.push_back(e);
        ->rd_ev;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick(1);
        we    = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(rd_ev);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: read strobe with empty expectation queue");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (rdata !== e.data || irq !== e.irq) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                             e.name, rdata, irq, e.data, e.irq);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; button = 5'h1F; we = 1'b0; addr = '0; wdata = '0;
        tick(3);
        rd(LV, 0, 0, "rst_level");
        rd(EV, 0, 0, "rst_event");
        rd(IE, 0, 0, "rst_irqen");
        button = 5'h0;
        tick(1);
        rst = 1'b1;
        tick(2);
        rd(EV, 0, 0, "post_rst_event");

        wr(IE, 32'h4);
        rd(IE, 32'h4, 0, "irqen_write");
        button = 5'b00100;
        tick(5); rd(LV, 0, 0, "press_lv_e4");
        tick(1); rd(LV, 32'h4, 0, "press_lv_e5"); rd(EV, 0, 0, "press_ev_e5");
        tick(1); rd(EV, 32'h4, 0, "press_ev_e6");
        tick(1); rd(EV, 32'h4, 1, "press_irq_e7");
        button = 5'b00000;
        tick(5); rd(LV, 32'h4, 1, "release_lv_e4");
        tick(1); rd(LV, 0, 1, "release_lv_e5"); rd(EV, 32'h4, 1, "release_no_event");

        button = 5'b00001;
        tick(7); rd(EV, 32'h5, 1, "event_5");
        button = 5'b00000;
        tick(6); rd(LV, 0, 1, "release_ch0");
        wdata = 32'h1; we = 1'b1;
        rd(EV, 32'h5, 1, "clr_pre_write_read");
        tick(1); we = 1'b0;
        rd(EV, 32'h4, 1, "clr_bit0");
        wr(EV, 32'h4);
        rd(EV, 0, 1, "clr_irq_lag");
        tick(1); rd(EV, 0, 0, "clr_irq_drop");

        button = 5'b00100;
        tick(6); rd(LV, 32'h4, 0, "collide_lv");
        wdata = 32'h4; we = 1'b1;
        rd(EV, 0, 0, "collide_pre");
        tick(1); we = 1'b0;
        rd(EV, 32'h4, 0, "set_wins");
        tick(1); rd(EV, 32'h4, 1, "set_wins_irq");
        button = 5'b00000;
        tick(6);
        wr(EV, 32'h1F);
        tick(1); rd(EV, 0, 0, "clear_all");

        button = 5'b00001;
        for (int k = 0; k < 3; k++) begin tick(1); rd(LV, 0, 0, "bounce_hi1"); end
        button = 5'b00000;
        tick(1); rd(LV, 0, 0, "bounce_lo");
        button = 5'b00001;
        for (int k = 0; k < 3; k++) begin tick(1); rd(LV, 0, 0, "bounce_hi2"); end
        button = 5'b00000;
        tick(6);
        rd(LV, 0, 0, "bounce_lv_end");
        rd(EV, 0, 0, "bounce_ev_end");

        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        wr(32'h0, 32'hFFFF_FFFF);
        wr(LV, 32'hFFFF_FFFF);
        rd(BASE + 32'hC, 0, 0, "decode_0c");
        rd(32'h0, 0, 0, "decode_zero");
        rd(LV, 0, 0, "decode_lv");
        rd(EV, 0, 0, "decode_ev");
        rd(IE, 32'h4, 0, "decode_ie");
        wr(IE, 32'hFFFF_FFFF);
        rd(IE, 32'h1F, 0, "irqen_mask");

        wr(IE, 32'h0);
        button = 5'b01000;
        tick(7); rd(EV, 32'h8, 0, "masked_event");
        tick(1); rd(EV, 32'h8, 0, "masked_no_irq");
        button = 5'b00000;
        tick(6);
        wr(IE, 32'h8);
        rd(IE, 32'h8, 0, "ien_lag");
        tick(1); rd(IE, 32'h8, 1, "ien_irq");

        button = 5'b00010;
        tick(4);
        rst = 1'b0;
        rd(EV, 0, 0, "midrst_event");
        rd(IE, 0, 0, "midrst_irqen");
        rd(LV, 0, 0, "midrst_level");
        tick(1);
        rst = 1'b1;
        tick(6); rd(LV, 32'h2, 0, "rerun_lv_e5"); rd(EV, 0, 0, "rerun_ev_e5");
        tick(1); rd(EV, 32'h2, 0, "rerun_ev_e6");

        #5;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
